// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int          ROM_AW           = 6;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the byte PC it came from.
    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-stage bus: ROM read port, redirect input and the instruction handshake.
interface if_prefetch_if;
    import fetch_pkg::*;

    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_code;
    logic [31:0]       inst_pc;

    // Fetch stage side.
    modport master (
        output rom_en, rom_addr, inst_valid, inst_code, inst_pc,
        input  rom_data, redirect, redirect_pc, inst_ready
    );

    // ROM / branch unit / decode side.
    modport slave (
        input  rom_en, rom_addr, inst_valid, inst_code, inst_pc,
        output rom_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_prefetch_inst_queue.sv
// Small synchronous FIFO of fetched {code, pc} entries with a flush.
module inst_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic         clka,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [QDEPTH];
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr;

    // Storage carries no reset: count alone decides what is live.
    always_ff @(posedge clka) begin
        if (push && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

    // The upstream credit rule must never let a push land on a full queue.
    assert property (@(posedge clka) disable iff (rst)
        (push && !flush) |-> (count < CW'(QDEPTH)));

    // Pointer distance and count must always agree.
    assert property (@(posedge clka) disable iff (rst)
        count == CW'(wr_ptr - rd_ptr));
endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch stage: owns the PC, issues ROM reads under queue credit,
// and presents fetched words through a valid/ready handshake.
module if_prefetch
    import fetch_pkg::*;
#(
    parameter  int          QDEPTH   = 2,
    parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int          CW       = $clog2(QDEPTH) + 1
) (
    input logic           clka,
    input logic           rst,
    if_prefetch_if.master bus
);
    logic [31:0]   fetch_pc;
    logic [31:0]   infl_pc;
    logic          infl_v;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;
    logic [CW:0]   occ;
    fetch_entry_t  din;
    fetch_entry_t  head;

    // A handshake coinciding with a redirect is not a consumption.
    assign pop  = bus.inst_valid & bus.inst_ready & ~bus.redirect;
    // The word returning under a redirect belongs to the old stream.
    assign push = infl_v & ~bus.redirect;

    // Occupancy after this edge: queued plus in-flight, minus what leaves now.
    assign occ = {1'b0, count} + (CW+1)'(infl_v) - (CW+1)'(pop);

    assign bus.rom_en   = ~rst & ~bus.redirect & (occ < (CW+1)'(QDEPTH));
    assign bus.rom_addr = fetch_pc[ROM_AW+1:2];

    assign din = '{code: bus.rom_data, pc: infl_pc};

    inst_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clka  (clka),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign bus.inst_valid = (count != '0);
    assign bus.inst_code  = head.code;
    assign bus.inst_pc    = head.pc;

    // PC and in-flight tag; redirect overrides issue.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            infl_v   <= 1'b0;
            infl_pc  <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & ~32'h3;
            infl_v   <= 1'b0;
        end else begin
            infl_v <= bus.rom_en;
            if (bus.rom_en) begin
                infl_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a 1-cycle-latency ROM model.
module tb_if_prefetch;
    logic clka = 1'b0;
    logic rst  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    if_prefetch_if bus ();

    if_prefetch #(.QDEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    // ROM: word index plus a recognisable base, one cycle after the request.
    always @(posedge clka) begin
        if (bus.rom_en)
            bus.rom_data <= 32'h1000_0000 + {26'd0, bus.rom_addr};
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Reset held across two edges, released mid-cycle.
    task automatic do_reset(input logic ready);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = ready;
        tick();
        tick();
        @(negedge clka);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b1;
        bus.rom_data    = 32'h0;
        tick();
        checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.rom_addr !== 6'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1'b1);
        #1;
        checks++; if (bus.rom_en !== 1'b1) begin failures++; $display("FAIL stream_first_issue got=%b exp=1", bus.rom_en); end
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_e1 got=%b exp=0", bus.inst_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 32'(i) * 4;
            checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.inst_valid); end
            checks++; if (bus.inst_pc !== exp_pc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.inst_pc, exp_pc); end
            checks++; if (bus.inst_code !== 32'h1000_0000 + 32'(i)) begin failures++; $display("FAIL stream_code[%0d] got=%h exp=%h", i, bus.inst_code, 32'h1000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        tick();
        tick();
        bus.inst_ready = 1'b0;
        #1;
        checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL stall_issue_stop got=%b exp=0", bus.rom_en); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b1) begin failures++; $display("FAIL stall_head[%0d] got=%h/%b exp=0/1", i, bus.inst_pc, bus.inst_valid); end
            checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL stall_rom_en[%0d] got=%b exp=0", i, bus.rom_en); end
        end
        bus.inst_ready = 1'b1;
        #1;
        checks++; if (bus.rom_en !== 1'b1) begin failures++; $display("FAIL stall_resume got=%b exp=1", bus.rom_en); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.inst_pc !== 32'(i) * 4 || bus.inst_code !== 32'h1000_0000 + 32'(i)) begin failures++; $display("FAIL stall_drain[%0d] got=%h/%h exp=%h/%h", i, bus.inst_pc, bus.inst_code, 32'(i) * 4, 32'h1000_0000 + 32'(i)); end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b1);
        tick();
        tick();
        bus.inst_ready = 1'b0;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0043;
        #1;
        checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL redir_full_issue got=%b exp=0", bus.rom_en); end
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.rom_addr !== 6'd16) begin failures++; $display("FAIL redir_full_addr got=%0d exp=16", bus.rom_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_full_valid_r0 got=%b exp=0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_full_valid_r1 got=%b exp=0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_code !== 32'h1000_0010) begin failures++; $display("FAIL redir_full_head got=%b/%h/%h exp=1/00000040/10000010", bus.inst_valid, bus.inst_pc, bus.inst_code); end
    endtask

    task automatic test_redirect_handshake();
        do_reset(1'b1);
        tick();
        tick();
        // Head pc 0 is being accepted and pc 4 is returning from the ROM.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0080;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_hs_valid_r0 got=%b exp=0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_hs_valid_r1 got=%b exp=0", bus.inst_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h80 + 32'(i) * 4 || bus.inst_code !== 32'h1000_0020 + 32'(i)) begin failures++; $display("FAIL redir_hs_stream[%0d] got=%b/%h/%h exp=1/%h/%h", i, bus.inst_valid, bus.inst_pc, bus.inst_code, 32'h80 + 32'(i) * 4, 32'h1000_0020 + 32'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        tick();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.redirect_pc = 32'h0000_02C0;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_r0 got=%b exp=0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_r1 got=%b exp=0", bus.inst_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.inst_pc !== 32'h2C0 + 32'(i) * 4 || bus.inst_code !== 32'h1000_0030 + 32'(i)) begin failures++; $display("FAIL b2b_stream[%0d] got=%h/%h exp=%h/%h", i, bus.inst_pc, bus.inst_code, 32'h2C0 + 32'(i) * 4, 32'h1000_0030 + 32'(i)); end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.rom_addr !== 6'd63) begin failures++; $display("FAIL wrap_addr got=%0d exp=63", bus.rom_addr); end
        tick();
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC || bus.inst_code !== 32'h1000_003F) begin failures++; $display("FAIL wrap_head got=%b/%h/%h exp=1/fffffffc/1000003f", bus.inst_valid, bus.inst_pc, bus.inst_code); end
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_code !== 32'h1000_0000) begin failures++; $display("FAIL wrap_next got=%b/%h/%h exp=1/00000000/10000000", bus.inst_valid, bus.inst_pc, bus.inst_code); end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clka);
        rst = 1'b1;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL midrst_rom_en got=%b exp=0", bus.rom_en); end
        checks++; if (bus.rom_addr !== 6'd0) begin failures++; $display("FAIL midrst_rom_addr got=%0d exp=0", bus.rom_addr); end
        tick();
        @(negedge clka);
        rst = 1'b0;
        tick();
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid_e1 got=%b exp=0", bus.inst_valid); end
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_code !== 32'h1000_0000) begin failures++; $display("FAIL midrst_restart got=%b/%h/%h exp=1/00000000/10000000", bus.inst_valid, bus.inst_pc, bus.inst_code); end
        tick();
        checks++; if (bus.inst_pc !== 32'h4 || bus.inst_code !== 32'h1000_0001) begin failures++; $display("FAIL midrst_second got=%h/%h exp=00000004/10000001", bus.inst_pc, bus.inst_code); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_handshake();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction fetch stage with a small prefetch queue, sitting between the instruction ROM (64 x 32-bit, synchronous read) and the decode/execute datapath. It owns the PC and issues one ROM read per cycle while queue credit exists. It presents fetched words with their PC through a valid/ready handshake. A redirect input (branch/jump target) flushes every queued and in-flight word and restarts fetch at the new PC.

## Interface
- `QDEPTH`, default 2: prefetch queue entries; must be a power of two and at least 2.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clka`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rom_en`, out, 1: ROM read request this cycle.
- `rom_addr`, out, 6: word address, equal to `fetch_pc[7:2]`.
- `rom_data`, in, 32: ROM read data, valid the cycle after the request edge.
- `redirect`, in, 1: flush and restart fetch.
- `redirect_pc`, in, 32: new fetch PC; bits [1:0] are forced to 0.
- `inst_valid`, out, 1: queue head holds an instruction.
- `inst_ready`, in, 1: consumer accepts the head.
- `inst_code`, out, 32: head instruction word.
- `inst_pc`, out, 32: byte PC of the head instruction.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - In-flight tag: `infl_v` and `infl_pc`.
  - Queue of {code, pc}: read pointer, write pointer and count, each `$clog2(QDEPTH)+1` bits wide.
- `pop = inst_valid & inst_ready & ~redirect`.
- Issue condition, combinational: `rom_en = ~rst & ~redirect & (count + infl_v - pop < QDEPTH)`.
- On a rising edge with `rom_en` set:
  - `infl_v <= 1`, `infl_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^32; `rom_addr` therefore wraps every 64 words.
- On a rising edge with `rom_en` clear: `infl_v <= 0`.
- On a rising edge with `infl_v` set and no redirect: push {`rom_data`, `infl_pc`} into the queue.
  - The credit rule guarantees the queue is never full at a push. A push into a full queue is a design error; flag it with an assertion.
- Pop on `pop` only. Push and pop in the same cycle leave `count` unchanged.
- `inst_valid = (count != 0)`. `inst_code` and `inst_pc` come from the queue head and are don't-care when `inst_valid` is 0.
- Redirect, sampled at the rising edge:
  - Clear `count` and both pointers.
  - Set `infl_v <= 0`; the ROM word returning this cycle is discarded.
  - Set `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Redirect takes priority over push, pop and issue. A handshake in the same cycle is not a consumption.
- Back-to-back redirects: the last one wins, and no word from an earlier target is ever presented.
- Reset values:
  - `fetch_pc = RESET_PC`, `infl_v = 0`, `count = 0`.
  - `rom_en = 0`, `inst_valid = 0`, `rom_addr = RESET_PC[7:2]`.
- Reset mid-operation clears everything immediately (asynchronously), with no partial push.

## Timing
- Fetch latency is 2 edges: address issued before edge E, data returns after E, pushed at E+1, `inst_valid` high after E+1.
- After reset release, the first instruction (PC `RESET_PC`) is valid after the second rising edge.
- After a redirect at edge R, the target instruction is valid after R+2, and `inst_valid` is 0 after R and R+1.
- Throughput is 1 instruction per cycle with `inst_ready` held high and `QDEPTH` at least 2.
- With `inst_ready` low, at most `QDEPTH` words are held (queue plus in-flight) and issue stops. After `inst_ready` rises, the head is consumed that cycle and issue resumes the same cycle.
- No combinational path exists from `rom_data` to any output. `inst_ready` and `redirect` reach `rom_en` combinationally.

## Structure
- Shared package `fetch_pkg` holds:
  - `ROM_AW = 6`, `PC_STEP = 4`, and the default `RESET_PC`.
  - A packed struct `fetch_entry_t` {code[31:0], pc[31:0]}.
- Sub-module `inst_queue`: a synchronous FIFO of `fetch_entry_t` with parameter `QDEPTH`.
  - Ports: push, pop, flush, head, count.
  - Uses the same `clka` and `rst`.
- The top level holds `fetch_pc`, the in-flight tag and the credit logic.

## Test plan
The bench ROM model returns `32'h1000_0000 + word index`, with a 1-cycle latency.

1. Reset, then `inst_ready` held at 1: valid after edge 2, then one instruction per cycle with pc 0, 4, 8 and codes 1000_0000, 1000_0001, 1000_0002.
2. `inst_ready` = 0 for 5 cycles after the first valid:
   - `rom_en` drops once `count + infl_v` reaches 2.
   - Head stays pc 0.
   - On release, pc 0, 4, 8 are delivered in order with no loss or duplication.
3. Redirect to 32'h0000_0043 while the queue is full:
   - `rom_addr` is 16 the next cycle.
   - `inst_valid` is 0 for 2 edges.
   - Next head is pc 32'h40, code 1000_0010.
4. Redirect in the same cycle as a handshake and an in-flight return:
   - The handshake is not counted.
   - The returning word is discarded.
   - Only the target stream appears.
5. PC wrap: redirect to 32'hFFFF_FFFC:
   - Head pc FFFF_FFFC, code 1000_003F.
   - Then pc 0, code 1000_0000.
6. Assert `rst` mid-stream, between edges:
   - `inst_valid` and `rom_en` go to 0 immediately.
   - After release, the stream restarts at `RESET_PC` with the same latency as scenario 1.
